// File: rtl/print_pkg.sv
// print_pkg: shared definitions for the print-string syscall engine.
//   state_t           - engine FSM states, also exported on the debug port
//   NUL_CHAR          - string terminator, never emitted
//   SYSCALL_PRINT_STR - syscall number ($v0) the decoder maps onto start
package print_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] NUL_CHAR          = 8'h00;
   localparam int         SYSCALL_PRINT_STR = 4;

endpackage

// File: rtl/byte_lane_select.sv
// byte_lane_select: little-endian byte extraction from a 32-bit word.
//   word      in  32  source word
//   off       in  2   byte offset, 0 selects bits 7:0
//   lane_byte out 8   selected byte
// Purely combinational; also intended for the lb/lbu load path.
module byte_lane_select (
   input  logic [31:0] word,
   input  logic [1:0]  off,
   output logic [7:0]  lane_byte
);

   always_comb begin
      lane_byte = word[7:0];
      case (off)
         2'd0:    lane_byte = word[7:0];
         2'd1:    lane_byte = word[15:8];
         2'd2:    lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
   end

endmodule

// File: rtl/syscall_print_engine.sv
// syscall_print_engine: streams a NUL-terminated string out of data memory.
//   clk, reset   system clock, synchronous active-high reset
//   start, a0    print request strobe and string byte address (taken in IDLE)
//   mem_addr     word-aligned read address, mem_read high only in FETCH
//   mem_rdata    combinational read data for mem_addr
//   char_out     character offered to the sink, qualified by char_valid
//   char_ready   sink accepts char_out in this cycle
//   busy, done   request in progress / one-cycle end-of-request pulse
//   truncated    MAX_LEN characters sent without a NUL; held until next start
//   state_dbg    current FSM state for observation
//
// Character handshake: a character moves on a rising edge where char_valid
// and char_ready are both high. Once char_valid rises, char_out and
// char_valid hold unchanged until that edge; char_ready may toggle freely.
module syscall_print_engine
   import print_pkg::*;
#(
   parameter int MAX_LEN = 4096,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] a0,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic [31:0]       mem_rdata,
   output logic [7:0]        char_out,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              busy,
   output logic              done,
   output logic              truncated,
   output state_t            state_dbg
);

   localparam int CNT_W = $clog2(MAX_LEN + 1);

   state_t            state;
   logic [ADDR_W-3:0] word_addr;
   logic [1:0]        byte_off;
   logic [31:0]       word_buf;
   logic [CNT_W-1:0]  count;

   logic [ADDR_W-3:0] word_addr_inc;
   logic [CNT_W-1:0]  count_inc;
   logic [31:0]       lane_word;
   logic [1:0]        lane_off;
   logic [7:0]        lane_byte;

   assign word_addr_inc = word_addr + {{(ADDR_W-3){1'b0}}, 1'b1};
   assign count_inc     = count + CNT_W'(1);
   assign state_dbg     = state;

   // The lane mux looks one byte ahead so char_out/char_valid can be
   // registered: in FETCH it picks the first byte straight off the memory
   // bus, in EMIT it picks the byte after the one currently offered.
   assign lane_word = (state == FETCH) ? mem_rdata : word_buf;
   assign lane_off  = (state == FETCH) ? byte_off  : byte_off + 2'd1;

   byte_lane_select u_lane (
      .word      (lane_word),
      .off       (lane_off),
      .lane_byte (lane_byte)
   );

   // In EMIT, char_valid is low exactly when the current byte is NUL, so it
   // doubles as the terminator flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         word_addr  <= '0;
         byte_off   <= '0;
         word_buf   <= '0;
         count      <= '0;
         mem_addr   <= '0;
         mem_read   <= 1'b0;
         char_out   <= '0;
         char_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         truncated  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  word_addr <= a0[ADDR_W-1:2];
                  byte_off  <= a0[1:0];
                  count     <= '0;
                  truncated <= 1'b0;
                  mem_addr  <= {a0[ADDR_W-1:2], 2'b00};
                  mem_read  <= 1'b1;
                  busy      <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               word_buf   <= mem_rdata;
               mem_read   <= 1'b0;
               char_out   <= lane_byte;
               char_valid <= (lane_byte != NUL_CHAR);
               state      <= EMIT;
            end
            EMIT: begin
               if (!char_valid) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (char_ready) begin
                  count <= count_inc;
                  if (count_inc == CNT_W'(MAX_LEN)) begin
                     truncated  <= 1'b1;
                     char_valid <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else if (byte_off == 2'd3) begin
                     byte_off   <= 2'd0;
                     word_addr  <= word_addr_inc;
                     mem_addr   <= {word_addr_inc, 2'b00};
                     mem_read   <= 1'b1;
                     char_valid <= 1'b0;
                     state      <= FETCH;
                  end else begin
                     byte_off   <= byte_off + 2'd1;
                     char_out   <= lane_byte;
                     char_valid <= (lane_byte != NUL_CHAR);
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/syscall_print_engine.md
Name: syscall_print_engine

Overview:
Synthesizable replacement for the behavioural print-string loop on the data-memory side. It consumes a print-syscall request carrying the string address from $a0. It fetches words from the data memory read port one at a time, extracts bytes little-endian (byte 0 = bits 7:0), and streams them over a valid/ready character interface until the NUL terminator. It sits directly downstream of data_memory's read port and upstream of the console/UART sink.

Parameters:
MAX_LEN, 4096, maximum characters emitted per request; runaway guard for unterminated strings
ADDR_W, 32, byte-address width of a0 and mem_addr

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  print request strobe (syscall 4 decoded); sampled only in IDLE
a0  in  ADDR_W  byte address of first character; latched on accepted start
mem_addr  out  ADDR_W  word-aligned read address to data memory ({word_addr, 2'b00})
mem_read  out  1  read enable, high only in FETCH
mem_rdata  in  32  combinational read data for mem_addr, valid in the same cycle
char_out  out  8  current character
char_valid  out  1  char_out holds a character to deliver
char_ready  in  1  sink accepts char_out this cycle
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse at end of request
truncated  out  1  set with done when MAX_LEN reached without NUL; held until next accepted start

Behaviour:
- Reset values: state=IDLE; char_valid, busy, done, mem_read, truncated = 0; char_out, mem_addr = 0. Reset mid-request aborts immediately: no done pulse, and a partially offered character is dropped.
- Registers: word_addr [ADDR_W-3:0], byte_off [1:0], word_buf [31:0], count [$clog2(MAX_LEN+1)-1:0].
- IDLE: if start, latch word_addr=a0[ADDR_W-1:2], byte_off=a0[1:0], count=0, truncated=0, then go to FETCH. busy rises the cycle after start.
- FETCH, 1 cycle: mem_read=1, mem_addr={word_addr,2'b00}. Latch word_buf=mem_rdata at the edge, then go to EMIT.
- EMIT: cur = word_buf[8*byte_off +: 8].
  - cur==0: go to DONE; NUL is never emitted.
  - Otherwise char_valid=1 and char_out=cur, both held stable until char_ready.
  - On char_valid&&char_ready: count+=1.
    - If the new count==MAX_LEN: truncated=1, go to DONE.
    - Else if byte_off==3: byte_off=0, word_addr+=1 (wraps modulo 2^(ADDR_W-2)), go to FETCH.
    - Else byte_off+=1 and stay in EMIT.
- DONE, 1 cycle: done=1, busy=1. Next state is IDLE.
- start asserted outside IDLE is ignored; it is neither queued nor able to disturb the active request.
- Latency: start at edge N gives FETCH in cycle N+1 and the first char_valid in cycle N+2. With char_ready tied high, throughput is 1 char/cycle within a word, plus 1 FETCH bubble per word crossing.
- An empty string (first byte NUL) produces done 3 cycles after start, with zero characters.
- char_valid deasserts in the cycle after the final handshake; it is never high in IDLE, FETCH or DONE.

Decomposition:
- Package print_pkg holds:
  - the state enum {IDLE, FETCH, EMIT, DONE}
  - NUL_CHAR = 8'h00
  - SYSCALL_PRINT_STR = 4
- One natural sub-module: byte_lane_select, a combinational mux taking word [31:0] and off [1:0] and producing byte [7:0], little-endian. It is shared with later lb/lbu support.
- The FSM and counters stay in syscall_print_engine.

Test Plan:
- Aligned "Hi": memory word 0x00400000 = 32'h00006948, a0=0x00400000, char_ready=1. Required: char_out 'H' then 'i' on consecutive cycles, done 1 cycle after 'i', exactly 1 mem_read, truncated=0.
- Unaligned, word-crossing: a0=0x00400002, word 0x00400000 = 32'h6261xxxx, word 0x00400004 = 32'h00000063. Required: "abc", 2 FETCH cycles, second mem_addr=0x00400004.
- Empty string: a0 points at byte 8'h00. Required: char_valid never rises, done 3 cycles after start.
- Backpressure: "Hi" with char_ready low for 5 cycles on 'H'. Required: char_out stays 'H' and char_valid stays 1 throughout, count unchanged, then 'i' is delivered; a start pulsed mid-request is ignored.
- Truncation: MAX_LEN=4, string "ABCDEFG\0". Required: exactly "ABCD", then done with truncated=1.
- Reset mid-stream: assert reset during the 2nd character of "Hello". Required: next cycle state=IDLE, char_valid=0, busy=0, no done pulse. A new start then prints the full string from its first character.
